// File: rtl/mb_spi_cfg_rx_if.sv
// SPI pin bundle between the MCU and the configuration receiver.
//   CLK  : SPI clock driven by the MCU (asynchronous to the FPGA clock)
//   MOSI : serial data, MSB first
//   LOAD : active-low frame strobe
// The master modport is the MCU side; the slave modport is the receiver.
interface mb_spi_cfg_rx_if;
    logic CLK;
    logic MOSI;
    logic LOAD;

    modport master (output CLK, output MOSI, output LOAD);
    modport slave  (input  CLK, input  MOSI, input  LOAD);
endinterface

// File: rtl/mb_spi_cfg_rx.sv
// Slave SPI receiver for MCU->FPGA configuration frames (MAC/IP, board options).
// The SPI pins are sampled in the clock domain. A frame is bounded by LOAD low.
// It is length-checked and, when CRC_EN=1, checked with a trailing CRC-8
// (poly 0x07, init 0). An accepted payload is published in a single cycle.
// A rejected frame is counted and thrown away.
//
// Ports
//   clock        : system clock
//   reset_n      : asynchronous active-low reset
//   spi          : SPI pins (CLK, MOSI, LOAD), slave modport
//   frame_data   : last accepted payload, MSB first on the wire
//   frame_valid  : one-cycle pulse when frame_data updates
//   frame_loaded : sticky, set by the first accepted frame
//   frame_err    : one-cycle pulse on a rejected or aborted frame
//   err_count    : rejected-frame count, saturates at 255
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for the synchronised LOAD to fall
// ST_RX    | LOAD low; shifting bits on the selected CLK edge
// ST_CHECK | one cycle; accept or reject the frame just closed
// ST_ABORT | timed out; ignore CLK until LOAD returns high
module mb_spi_cfg_rx #(
    parameter int PAYLOAD_BITS   = 80,
    parameter int CRC_EN         = 1,
    parameter int SAMPLE_EDGE    = 0,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    mb_spi_cfg_rx_if.slave          spi,
    output logic [PAYLOAD_BITS-1:0] frame_data,
    output logic                    frame_valid,
    output logic                    frame_loaded,
    output logic                    frame_err,
    output logic [7:0]              err_count
);

    localparam int FRAME_BITS = PAYLOAD_BITS + ((CRC_EN != 0) ? 8 : 0);
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);
    localparam int TMO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit CRC_CHK    = (CRC_EN != 0);
    localparam bit TMO_EN     = (TIMEOUT_CYCLES != 0);
    localparam bit FALL_EDGE  = (SAMPLE_EDGE != 0);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RX,
        ST_CHECK,
        ST_ABORT
    } state_t;

    logic [SYNC_STAGES-1:0]  clk_sync_q,  clk_sync_d;
    logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0]  load_sync_q, load_sync_d;
    logic                    clk_dly_q,   clk_dly_d;
    logic                    load_dly_q,  load_dly_d;

    state_t                  state_q,        state_d;
    logic [FRAME_BITS-1:0]   sr_q,           sr_d;
    logic [CNT_W-1:0]        cnt_q,          cnt_d;
    logic [7:0]              crc_q,          crc_d;
    logic [TMO_W-1:0]        tmo_q,          tmo_d;
    logic [PAYLOAD_BITS-1:0] frame_data_q,   frame_data_d;
    logic                    frame_valid_q,  frame_valid_d;
    logic                    frame_loaded_q, frame_loaded_d;
    logic                    frame_err_q,    frame_err_d;
    logic [7:0]              err_count_q,    err_count_d;

    logic       clk_s, mosi_s, load_s;
    logic       load_fall, load_rise, sample_edge;
    logic [7:0] crc_next;
    logic [7:0] err_count_inc;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign load_s = load_sync_q[SYNC_STAGES-1];

    assign load_fall   = load_dly_q & ~load_s;
    assign load_rise   = ~load_dly_q & load_s;
    assign sample_edge = FALL_EDGE ? (clk_dly_q & ~clk_s) : (~clk_dly_q & clk_s);

    // Serial CRC-8, one bit per sample edge; a frame carrying its own CRC
    // leaves a zero residue.
    assign crc_next      = {crc_q[6:0], 1'b0} ^ ({8{crc_q[7] ^ mosi_s}} & 8'h07);
    assign err_count_inc = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0],  spi.CLK};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.MOSI};
        load_sync_d = {load_sync_q[SYNC_STAGES-2:0], spi.LOAD};
        clk_dly_d   = clk_s;
        load_dly_d  = load_s;

        state_d        = state_q;
        sr_d           = sr_q;
        cnt_d          = cnt_q;
        crc_d          = crc_q;
        tmo_d          = tmo_q;
        frame_data_d   = frame_data_q;
        frame_valid_d  = 1'b0;
        frame_loaded_d = frame_loaded_q;
        frame_err_d    = 1'b0;
        err_count_d    = err_count_q;

        case (state_q)
            ST_IDLE: begin
                if (load_fall) begin
                    state_d = ST_RX;
                    cnt_d   = '0;
                    crc_d   = '0;
                    tmo_d   = TMO_LOAD;
                end
            end

            ST_RX: begin
                // LOAD rise wins over a CLK edge in the same cycle, so that
                // edge never reaches the shift register.
                if (load_rise) begin
                    state_d = ST_CHECK;
                end else if (load_fall) begin
                    cnt_d = '0;
                    crc_d = '0;
                    tmo_d = TMO_LOAD;
                end else if (sample_edge) begin
                    sr_d  = {sr_q[FRAME_BITS-2:0], mosi_s};
                    crc_d = crc_next;
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    tmo_d = TMO_LOAD;
                end else if (TMO_EN) begin
                    if (tmo_q <= TMO_W'(1)) begin
                        state_d     = ST_ABORT;
                        frame_err_d = 1'b1;
                        err_count_d = err_count_inc;
                    end else begin
                        tmo_d = tmo_q - TMO_W'(1);
                    end
                end
            end

            ST_CHECK: begin
                state_d = ST_IDLE;
                if ((cnt_q == CNT_FULL) && (!CRC_CHK || (crc_q == 8'h00))) begin
                    frame_data_d   = sr_q[FRAME_BITS-1 -: PAYLOAD_BITS];
                    frame_valid_d  = 1'b1;
                    frame_loaded_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                    err_count_d = err_count_inc;
                end
            end

            ST_ABORT: begin
                // The error was already raised on entry; the LOAD rise that
                // closes the aborted frame is silent.
                if (load_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q     <= '1;
            mosi_sync_q    <= '1;
            load_sync_q    <= '1;
            clk_dly_q      <= 1'b1;
            load_dly_q     <= 1'b1;
            state_q        <= ST_IDLE;
            sr_q           <= '0;
            cnt_q          <= '0;
            crc_q          <= '0;
            tmo_q          <= '0;
            frame_data_q   <= '0;
            frame_valid_q  <= 1'b0;
            frame_loaded_q <= 1'b0;
            frame_err_q    <= 1'b0;
            err_count_q    <= '0;
        end else begin
            clk_sync_q     <= clk_sync_d;
            mosi_sync_q    <= mosi_sync_d;
            load_sync_q    <= load_sync_d;
            clk_dly_q      <= clk_dly_d;
            load_dly_q     <= load_dly_d;
            state_q        <= state_d;
            sr_q           <= sr_d;
            cnt_q          <= cnt_d;
            crc_q          <= crc_d;
            tmo_q          <= tmo_d;
            frame_data_q   <= frame_data_d;
            frame_valid_q  <= frame_valid_d;
            frame_loaded_q <= frame_loaded_d;
            frame_err_q    <= frame_err_d;
            err_count_q    <= err_count_d;
        end
    end

    assign frame_data   = frame_data_q;
    assign frame_valid  = frame_valid_q;
    assign frame_loaded = frame_loaded_q;
    assign frame_err    = frame_err_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_mb_spi_cfg_rx.sv
// Bench for mb_spi_cfg_rx. Two receivers share one clock and reset:
//   dut_a : 80-bit payload + CRC-8, rising-edge sampling, 100-cycle timeout
//   dut_b : 16-bit payload, no CRC, falling-edge sampling
// Expected results come from a frame-level model: a frame is accepted when
// it has exactly FRAME_BITS bits and its CRC-8 residue is zero.
module tb_mb_spi_cfg_rx;

    localparam int PA    = 80;
    localparam int PB    = 16;
    localparam int FA    = PA + 8;
    localparam int TMO_A = 100;
    localparam int SYNC  = 2;

    typedef bit bitq_t[$];

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic spi_clk[2];
    logic spi_mosi[2];
    logic spi_load[2];

    mb_spi_cfg_rx_if ifa ();
    mb_spi_cfg_rx_if ifb ();
    assign ifa.CLK  = spi_clk[0];
    assign ifa.MOSI = spi_mosi[0];
    assign ifa.LOAD = spi_load[0];
    assign ifb.CLK  = spi_clk[1];
    assign ifb.MOSI = spi_mosi[1];
    assign ifb.LOAD = spi_load[1];

    logic [PA-1:0] fd_a;
    logic          fv_a, fl_a, fe_a;
    logic [7:0]    ec_a;
    logic [PB-1:0] fd_b;
    logic          fv_b, fl_b, fe_b;
    logic [7:0]    ec_b;

    mb_spi_cfg_rx #(.PAYLOAD_BITS(PA), .CRC_EN(1), .SAMPLE_EDGE(0),
                    .TIMEOUT_CYCLES(TMO_A), .SYNC_STAGES(SYNC)) dut_a (
        .clock(clock), .reset_n(reset_n), .spi(ifa),
        .frame_data(fd_a), .frame_valid(fv_a), .frame_loaded(fl_a),
        .frame_err(fe_a), .err_count(ec_a));

    mb_spi_cfg_rx #(.PAYLOAD_BITS(PB), .CRC_EN(0), .SAMPLE_EDGE(1),
                    .TIMEOUT_CYCLES(65535), .SYNC_STAGES(SYNC)) dut_b (
        .clock(clock), .reset_n(reset_n), .spi(ifb),
        .frame_data(fd_b), .frame_valid(fv_b), .frame_loaded(fl_b),
        .frame_err(fe_b), .err_count(ec_b));

    int checks = 0;
    int errors = 0;
    int vcnt[2] = '{0, 0};
    int ecnt[2] = '{0, 0};

    // reference model state
    logic [PA-1:0] m_data_a   = '0;
    bit            m_loaded_a = 1'b0;
    int            m_errs_a   = 0;
    logic [PB-1:0] m_data_b   = '0;
    int            m_errs_b   = 0;

    always @(negedge clock) begin
        if (fv_a) vcnt[0] <= vcnt[0] + 1;
        if (fe_a) ecnt[0] <= ecnt[0] + 1;
        if (fv_b) vcnt[1] <= vcnt[1] + 1;
        if (fe_b) ecnt[1] <= ecnt[1] + 1;
    end

    // ---------------- model ----------------
    function automatic logic [7:0] crc8(input bitq_t q);
        logic [7:0] c;
        bit         fb;
        c = 8'h00;
        foreach (q[i]) begin
            fb = c[7] ^ q[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    function automatic bitq_t make_frame(input logic [255:0] val, input int nbits, input bit add_crc);
        bitq_t      q;
        logic [7:0] c;
        for (int i = nbits - 1; i >= 0; i--) q.push_back(val[i]);
        if (add_crc) begin
            c = crc8(q);
            for (int i = 7; i >= 0; i--) q.push_back(c[i]);
        end
        return q;
    endfunction

    function automatic bit model_accept(input bitq_t q, input int frame_bits, input bit crc_en);
        return (q.size() == frame_bits) && (!crc_en || (crc8(q) == 8'h00));
    endfunction

    function automatic logic [255:0] payload_of(input bitq_t q, input int n);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = {v[254:0], q[i]};
        return v;
    endfunction

    function automatic logic [255:0] rand_val();
        logic [255:0] v;
        v = '0;
        v[31:0]   = $urandom;
        v[63:32]  = $urandom;
        v[95:64]  = $urandom;
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    // dut_a: MOSI changes while CLK low, sampled on the rise.
    // dut_b: MOSI changes on the rise, sampled on the fall. SPI CLK = clock/8.
    task automatic clock_bits(input int sel, input bitq_t q);
        bit lead;
        lead = (sel == 1);
        foreach (q[i]) begin
            spi_clk[sel]  = lead;
            spi_mosi[sel] = q[i];
            wait_cyc(4);
            spi_clk[sel]  = ~lead;
            wait_cyc(4);
        end
    endtask

    task automatic send_frame(input int sel, input bitq_t q, output int nv, output int ne, output int lat);
        int v0, e0;
        v0  = vcnt[sel];
        e0  = ecnt[sel];
        lat = -1;
        spi_load[sel] = 1'b0;
        wait_cyc(4);
        clock_bits(sel, q);
        spi_clk[sel] = 1'b0;
        wait_cyc(4);
        spi_load[sel] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clock);
            #1;
            if (lat < 0 && ((sel == 0) ? (fv_a | fe_a) : (fv_b | fe_b))) lat = k;
        end
        wait_cyc(1);
        nv = vcnt[sel] - v0;
        ne = ecnt[sel] - e0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        wait_cyc(3);
        checks++; if (fd_a !== '0)    begin errors++; $display("FAIL reset_fd_a got %h exp 0", fd_a); end
        checks++; if (fv_a !== 1'b0 || fe_a !== 1'b0) begin errors++; $display("FAIL reset_pulses_a got v=%b e=%b exp 0 0", fv_a, fe_a); end
        checks++; if (fl_a !== 1'b0)  begin errors++; $display("FAIL reset_loaded_a got %b exp 0", fl_a); end
        checks++; if (ec_a !== 8'd0)  begin errors++; $display("FAIL reset_ec_a got %0d exp 0", ec_a); end
        checks++; if (fd_b !== '0 || ec_b !== 8'd0) begin errors++; $display("FAIL reset_b got %h/%0d exp 0/0", fd_b, ec_b); end
        reset_n = 1'b1;
        wait_cyc(4);
    endtask

    task automatic test_valid_frame();
        bitq_t q;
        int nv, ne, lat;
        q = make_frame(256'h001CC0A21317_C0A80164, PA, 1'b1);
        send_frame(0, q, nv, ne, lat);
        m_data_a = 80'h001CC0A21317_C0A80164;
        m_loaded_a = 1'b1;
        checks++; if (nv !== 1 || ne !== 0) begin errors++; $display("FAIL valid_pulses got v=%0d e=%0d exp 1 0", nv, ne); end
        checks++; if (lat !== SYNC + 2) begin errors++; $display("FAIL valid_latency got %0d exp %0d", lat, SYNC + 2); end
        checks++; if (fd_a !== m_data_a) begin errors++; $display("FAIL valid_data got %h exp %h", fd_a, m_data_a); end
        checks++; if (fl_a !== 1'b1 || ec_a !== 8'd0) begin errors++; $display("FAIL valid_status got l=%b ec=%0d exp 1 0", fl_a, ec_a); end
    endtask

    task automatic test_crc_error();
        bitq_t q;
        int nv, ne, lat;
        q = make_frame(256'h001CC0A21317_C0A80164, PA, 1'b1);
        q[FA-1] = ~q[FA-1];
        send_frame(0, q, nv, ne, lat);
        m_errs_a++;
        checks++; if (nv !== 0 || ne !== 1) begin errors++; $display("FAIL crc_pulses got v=%0d e=%0d exp 0 1", nv, ne); end
        checks++; if (lat !== SYNC + 2) begin errors++; $display("FAIL crc_err_latency got %0d exp %0d", lat, SYNC + 2); end
        checks++; if (ec_a !== 8'(m_errs_a) || fd_a !== m_data_a) begin errors++; $display("FAIL crc_state got ec=%0d fd=%h exp %0d %h", ec_a, fd_a, m_errs_a, m_data_a); end
    endtask

    task automatic test_length_errors();
        bitq_t q, base;
        int nv, ne, lat;
        base = make_frame(rand_val(), PA, 1'b1);
        for (int t = 0; t < 3; t++) begin
            q = base;
            if (t == 0) void'(q.pop_back());
            else if (t == 1) q.push_back(1'b0);
            else q.delete();
            send_frame(0, q, nv, ne, lat);
            m_errs_a++;
            checks++; if (nv !== 0 || ne !== 1) begin errors++; $display("FAIL length_%0d_pulses got v=%0d e=%0d exp 0 1", q.size(), nv, ne); end
            checks++; if (ec_a !== 8'(m_errs_a) || fd_a !== m_data_a) begin errors++; $display("FAIL length_%0d_state got ec=%0d fd=%h exp %0d %h", q.size(), ec_a, fd_a, m_errs_a, m_data_a); end
        end
    endtask

    task automatic test_random_frames();
        bitq_t q;
        int nv, ne, lat, kind, idx;
        bit ok;
        for (int it = 0; it < 12; it++) begin
            q = make_frame(rand_val(), PA, 1'b1);
            kind = $urandom_range(0, 2);
            if (kind == 1) begin
                idx = $urandom_range(0, FA - 1);
                q[idx] = ~q[idx];
            end else if (kind == 2) begin
                if ($urandom_range(0, 1) == 1) void'(q.pop_back());
                else q.push_back(1'($urandom));
            end
            send_frame(0, q, nv, ne, lat);
            ok = model_accept(q, FA, 1'b1);
            if (ok) begin
                m_data_a = PA'(payload_of(q, PA));
                m_loaded_a = 1'b1;
            end else if (m_errs_a < 255) begin
                m_errs_a++;
            end
            checks++; if (nv !== int'(ok) || ne !== int'(!ok)) begin errors++; $display("FAIL random_%0d_pulses got v=%0d e=%0d exp %0d %0d", it, nv, ne, ok, !ok); end
            checks++; if (fd_a !== m_data_a || ec_a !== 8'(m_errs_a)) begin errors++; $display("FAIL random_%0d_state got fd=%h ec=%0d exp %h %0d", it, fd_a, ec_a, m_data_a, m_errs_a); end
        end
    endtask

    task automatic test_timeout();
        bitq_t q;
        int nv, ne, lat, v0, e0;
        v0 = vcnt[0];
        e0 = ecnt[0];
        q = make_frame(rand_val(), PA, 1'b1);
        spi_load[0] = 1'b0;
        wait_cyc(4);
        for (int i = 0; i < 40; i++) begin
            spi_clk[0]  = 1'b0;
            spi_mosi[0] = q[i];
            wait_cyc(4);
            spi_clk[0]  = 1'b1;
            if (i < 39) wait_cyc(4);
        end
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clock);
            #1;
            if (fe_a) begin
                lat = k;
                break;
            end
        end
        m_errs_a++;
        checks++; if (lat < TMO_A || lat > TMO_A + SYNC + 4) begin errors++; $display("FAIL timeout_delay got %0d exp %0d..%0d", lat, TMO_A, TMO_A + SYNC + 4); end
        for (int i = 0; i < 10; i++) begin
            spi_clk[0] = 1'b0;
            wait_cyc(4);
            spi_clk[0] = 1'b1;
            wait_cyc(4);
        end
        spi_clk[0] = 1'b0;
        wait_cyc(4);
        spi_load[0] = 1'b1;
        wait_cyc(15);
        checks++; if (ecnt[0] - e0 !== 1 || vcnt[0] - v0 !== 0) begin errors++; $display("FAIL timeout_single_err got e=%0d v=%0d exp 1 0", ecnt[0] - e0, vcnt[0] - v0); end
        checks++; if (ec_a !== 8'(m_errs_a) || fd_a !== m_data_a) begin errors++; $display("FAIL timeout_state got ec=%0d fd=%h exp %0d %h", ec_a, fd_a, m_errs_a, m_data_a); end
        q = make_frame(rand_val(), PA, 1'b1);
        send_frame(0, q, nv, ne, lat);
        m_data_a = PA'(payload_of(q, PA));
        checks++; if (nv !== 1 || fd_a !== m_data_a) begin errors++; $display("FAIL timeout_recover got v=%0d fd=%h exp 1 %h", nv, fd_a, m_data_a); end
    endtask

    task automatic test_sample_edge();
        bitq_t q;
        int nv, ne, lat;
        bit ok;
        for (int it = 0; it < 7; it++) begin
            if (it == 0)      q = make_frame(256'hA55A, PB, 1'b0);
            else if (it == 5) q = make_frame(rand_val(), PB - 1, 1'b0);
            else if (it == 6) q = make_frame(rand_val(), PB + 1, 1'b0);
            else              q = make_frame(rand_val(), PB, 1'b0);
            send_frame(1, q, nv, ne, lat);
            ok = model_accept(q, PB, 1'b0);
            if (ok) m_data_b = PB'(payload_of(q, PB));
            else m_errs_b++;
            checks++; if (nv !== int'(ok) || ne !== int'(!ok) || lat !== SYNC + 2) begin errors++; $display("FAIL edge_%0d_pulses got v=%0d e=%0d lat=%0d exp %0d %0d %0d", it, nv, ne, lat, ok, !ok, SYNC + 2); end
            checks++; if (fd_b !== m_data_b || ec_b !== 8'(m_errs_b) || fl_b !== 1'b1) begin errors++; $display("FAIL edge_%0d_state got fd=%h ec=%0d l=%b exp %h %0d 1", it, fd_b, ec_b, fl_b, m_data_b, m_errs_b); end
        end
    endtask

    task automatic test_mid_frame_reset();
        bitq_t q, head, tail;
        int nv, ne, lat, v0;
        q = make_frame(rand_val(), PA, 1'b1);
        foreach (q[i]) begin
            if (i < 30) head.push_back(q[i]);
            else tail.push_back(q[i]);
        end
        v0 = vcnt[0];
        spi_load[0] = 1'b0;
        wait_cyc(4);
        clock_bits(0, head);
        reset_n = 1'b0;
        wait_cyc(2);
        m_data_a = '0;
        m_loaded_a = 1'b0;
        m_errs_a = 0;
        checks++; if (fd_a !== '0 || fl_a !== 1'b0 || ec_a !== 8'd0) begin errors++; $display("FAIL midreset_clear got fd=%h l=%b ec=%0d exp 0 0 0", fd_a, fl_a, ec_a); end
        reset_n = 1'b1;
        clock_bits(0, tail);
        spi_clk[0] = 1'b0;
        wait_cyc(4);
        spi_load[0] = 1'b1;
        wait_cyc(15);
        checks++; if (vcnt[0] - v0 !== 0 || fd_a !== '0) begin errors++; $display("FAIL midreset_no_valid got v=%0d fd=%h exp 0 0", vcnt[0] - v0, fd_a); end
        q = make_frame(rand_val(), PA, 1'b1);
        send_frame(0, q, nv, ne, lat);
        m_data_a = PA'(payload_of(q, PA));
        m_loaded_a = 1'b1;
        checks++; if (nv !== 1 || fd_a !== m_data_a || fl_a !== m_loaded_a) begin errors++; $display("FAIL midreset_next got v=%0d fd=%h l=%b exp 1 %h 1", nv, fd_a, fl_a, m_data_a); end
    endtask

    task automatic test_saturation();
        int v0, e0;
        v0 = vcnt[0];
        e0 = ecnt[0];
        for (int i = 0; i < 300; i++) begin
            spi_load[0] = 1'b0;
            wait_cyc(3);
            spi_load[0] = 1'b1;
            wait_cyc(6);
        end
        wait_cyc(10);
        m_errs_a = (m_errs_a + 300 > 255) ? 255 : m_errs_a + 300;
        checks++; if (ec_a !== 8'(m_errs_a)) begin errors++; $display("FAIL sat_count got %0d exp %0d", ec_a, m_errs_a); end
        checks++; if (ecnt[0] - e0 !== 300 || vcnt[0] - v0 !== 0) begin errors++; $display("FAIL sat_pulses got e=%0d v=%0d exp 300 0", ecnt[0] - e0, vcnt[0] - v0); end
        checks++; if (fd_a !== m_data_a) begin errors++; $display("FAIL sat_data got %h exp %h", fd_a, m_data_a); end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            spi_clk[s]  = 1'b0;
            spi_mosi[s] = 1'b0;
            spi_load[s] = 1'b1;
        end
        test_reset();
        test_valid_frame();
        test_crc_error();
        test_length_errors();
        test_random_frames();
        test_timeout();
        test_sample_edge();
        test_mid_frame_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
